psum_acc_sfp: RTL
=================

Name: psum_acc_sfp

Overview:
- Consumer end of the accumulation instruction stream: inst[33] (acc) and inst[34] (Choice) from the core bench/controller.
- Sums one psum-memory row per acc cycle across a kij run.
- Optionally adds a residual vector, applies ReLU, and presents the result on sfp_out with a one-cycle valid pulse.
- Sits between the psum SRAM read port and the core's sfp_out output.

Parameters:
- col, 8, number of output-channel lanes
- psum_bw, 16, signed lane width of psum, residual and output
- len_kij, 9, expected acc cycles per output pixel

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state and outputs
- acc  input  1  psum_in valid this cycle; accumulate it
- choice  input  1  0 = VGG (ReLU only), 1 = ResNet (residual add, then ReLU)
- clear  input  1  synchronous abort of the current run
- psum_in  input  col*psum_bw  psum SRAM read data, lane k at [k*psum_bw +: psum_bw], two's complement
- resdual  input  col*psum_bw  residual vector, same lane packing
- sfp_out  output  col*psum_bw  registered result, held until the next emit
- out_valid  output  1  one-cycle pulse when sfp_out updates
- busy  output  1  high in ACCUM or EMIT
- acc_cnt  output  4  acc cycles counted in the current or last run
- cnt_err  output  1  last emitted run had acc_cnt != len_kij

Behaviour:
- Reset (async, immediate):
  - sfp_out=0, out_valid=0, busy=0, acc_cnt=0, cnt_err=0.
  - Lane accumulators and residual register = 0.
  - state=IDLE.
- States: IDLE, ACCUM, EMIT.
- IDLE:
  - acc=1: sum[k] <= psum_in[k] (load, not add), acc_cnt <= 1, go ACCUM.
  - Otherwise hold.
- ACCUM:
  - acc=1: sum[k] <= sat(sum[k] + psum_in[k]). acc_cnt increments and saturates at 15.
  - acc=0: res_q <= (choice ? resdual : 0). choice is sampled on this edge. Go EMIT.
- EMIT:
  - sfp_out[k] <= relu(sat(sum[k] + res_q[k])).
  - out_valid <= 1 for this one edge only.
  - cnt_err <= (acc_cnt != len_kij).
  - If acc=1 on the same edge: new run starts with sum <= psum_in, acc_cnt <= 1, go ACCUM. Otherwise go IDLE.
- Latency: out_valid is high in the second cycle after the last acc=1 cycle (ACCUM edge, then EMIT edge).
- Arithmetic:
  - Every add is done at psum_bw+1 bits, then saturated to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - relu(x) = 0 if x<0, else x.
  - Lanes are independent; there is no cross-lane carry.
- clear:
  - In ACCUM or EMIT: go IDLE on that edge, no out_valid pulse. sfp_out and cnt_err are unchanged. acc_cnt <= 0.
  - clear beats acc on the same edge.
  - In IDLE: no effect except acc_cnt <= 0.
- Hold behaviour:
  - sfp_out and cnt_err hold between emits.
  - out_valid is 0 in every cycle except the cycle after an EMIT edge.
- busy = (state != IDLE); it is combinational from the state register.
- acc toggling mid-run:
  - acc=0 for one cycle ends the run.
  - A following acc=1 starts a new run; no gap is required beyond the EMIT cycle.
- Reset mid-run: the run is discarded and no pulse is produced. Outputs are 0 as soon as reset asserts.

Test Plan:
- VGG basic: reset, choice=0, 9 consecutive acc cycles, lane k psum_in = k+1.
  - sfp_out lanes 0..7 = 9,18,27,36,45,54,63,72.
  - out_valid is a single pulse exactly 2 cycles after the last acc; cnt_err=0; acc_cnt=9.
- ReLU: lane0 psum_in = -100 for 9 cycles, other lanes = 5.
  - lane0 = 0; lanes 1..7 = 45.
- Saturation: all lanes 0x7000 for 9 cycles → every lane 0x7FFF.
  - All lanes 0x9000 for 9 cycles → every lane 0 (clamped to -32768, then ReLU).
- Residual: choice=1, resdual all lanes = -50, psum as in the VGG test.
  - Lanes 0..4 = 0; lanes 5..7 = 4,13,22.
  - Same stimulus with choice=0 → 9..72.
- Count error / back-to-back:
  - 5-cycle run → out_valid pulses, lane k = 5(k+1), cnt_err=1.
  - Immediately follow with a 9-cycle run starting in the EMIT cycle → second pulse with correct sums, cnt_err=0.
- Abort:
  - clear asserted on acc cycle 4 → no out_valid, busy=0 next cycle, sfp_out keeps its previous value.
  - Async reset asserted mid-run, between clock edges → sfp_out=0, out_valid=0, busy=0 immediately.

Source files
------------

// File: rtl/psum_acc_sfp.sv
// Accumulates one psum row per acc cycle across a kij run, then optionally adds
// a residual, applies ReLU and emits the lane vector with a one-cycle valid pulse.
module psum_acc_sfp #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int len_kij = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   acc,
  input  logic                   choice,
  input  logic                   clear,
  input  logic [col*psum_bw-1:0] psum_in,
  input  logic [col*psum_bw-1:0] resdual,
  output logic [col*psum_bw-1:0] sfp_out,
  output logic                   out_valid,
  output logic                   busy,
  output logic [3:0]             acc_cnt,
  output logic                   cnt_err
);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  localparam logic [3:0] LEN_CNT = 4'(len_kij);

  state_t state, state_nxt;

  logic signed [psum_bw-1:0] sum_q   [col];
  logic signed [psum_bw-1:0] res_q   [col];
  logic signed [psum_bw-1:0] add_lane[col];
  logic [col*psum_bw-1:0]    emit_vec;

  // One guard bit catches any overflow of a two-operand add; clamp on sign disagreement.
  function automatic logic signed [psum_bw-1:0] sat_add(
    input logic signed [psum_bw-1:0] a,
    input logic signed [psum_bw-1:0] b
  );
    logic signed [psum_bw:0] s;
    s = $signed({a[psum_bw-1], a}) + $signed({b[psum_bw-1], b});
    if (s[psum_bw] != s[psum_bw-1])
      sat_add = s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    else
      sat_add = s[psum_bw-1:0];
  endfunction

  function automatic logic [psum_bw-1:0] relu(input logic signed [psum_bw-1:0] x);
    relu = x[psum_bw-1] ? '0 : x;
  endfunction

  always_comb begin
    emit_vec = '0;
    for (int k = 0; k < col; k++) begin
      add_lane[k] = sat_add(sum_q[k], $signed(psum_in[k*psum_bw +: psum_bw]));
      emit_vec[k*psum_bw +: psum_bw] = relu(sat_add(sum_q[k], res_q[k]));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // clear always wins over acc, including a new run starting in the EMIT cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!clear && acc) state_nxt = ACCUM;
      ACCUM:   if (clear) state_nxt = IDLE;
               else if (!acc) state_nxt = EMIT;
      EMIT:    if (!clear && acc) state_nxt = ACCUM;
               else state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sfp_out   <= '0;
      out_valid <= 1'b0;
      acc_cnt   <= '0;
      cnt_err   <= 1'b0;
      for (int k = 0; k < col; k++) begin
        sum_q[k] <= '0;
        res_q[k] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (clear) begin
        acc_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (acc) begin
              for (int k = 0; k < col; k++)
                sum_q[k] <= $signed(psum_in[k*psum_bw +: psum_bw]);
              acc_cnt <= 4'd1;
            end
          end
          ACCUM: begin
            if (acc) begin
              for (int k = 0; k < col; k++)
                sum_q[k] <= add_lane[k];
              if (acc_cnt != 4'hF) acc_cnt <= acc_cnt + 4'd1;
            end else begin
              for (int k = 0; k < col; k++)
                res_q[k] <= choice ? $signed(resdual[k*psum_bw +: psum_bw]) : '0;
            end
          end
          EMIT: begin
            sfp_out   <= emit_vec;
            out_valid <= 1'b1;
            cnt_err   <= (acc_cnt != LEN_CNT);
            if (acc) begin
              for (int k = 0; k < col; k++)
                sum_q[k] <= $signed(psum_in[k*psum_bw +: psum_bw]);
              acc_cnt <= 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
